// File: rtl/perph_defs_pkg.sv
// Shared peripheral definitions: register window base and GPIO register indices.
package perph_defs;

    // Default base of the GPIO register window (32-byte aligned).
    localparam logic [31:0] GPIO_BASE_ADDR = 32'h8000_0000;

    // Register index is the word offset inside the 32-byte window.
    localparam int unsigned REG_IDX_W = 3;

    localparam logic [REG_IDX_W-1:0] REG_OUT   = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_DIR   = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_IN    = 3'd2;
    localparam logic [REG_IDX_W-1:0] REG_SET   = 3'd3;
    localparam logic [REG_IDX_W-1:0] REG_CLR   = 3'd4;
    localparam logic [REG_IDX_W-1:0] REG_TGL   = 3'd5;
    localparam logic [REG_IDX_W-1:0] REG_EDGE  = 3'd6;
    localparam logic [REG_IDX_W-1:0] REG_IRQEN = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Per-bit flop chain bringing asynchronous pad inputs into the i_clk domain.
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the pad value through STAGES flops; the last stage is the safe sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_async;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_sync = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_mmio_ctrl.sv
// Memory-mapped GPIO controller: output/direction registers, atomic
// set/clear/toggle, synchronized inputs, rising-edge capture and a level IRQ.
//
// Bus handshake: i_read_cs / i_write_cs are single-cycle strobes that are
// always accepted (no ready, no stall). A read strobe produces o_rvalid high
// for exactly the following cycle with o_rdata loaded at the strobe edge;
// o_rdata holds its value when no read is issued.
module gpio_mmio_ctrl
    import perph_defs::*;
#(
    parameter logic [31:0] BASE_ADDR   = GPIO_BASE_ADDR,
    parameter int unsigned NUM_PINS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_read_cs,
    input  logic                i_write_cs,
    input  logic [31:0]         i_address,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata,
    output logic                o_rvalid,
    input  logic [NUM_PINS-1:0] i_gpio_in,
    output logic [NUM_PINS-1:0] o_gpio_out,
    output logic [NUM_PINS-1:0] o_gpio_oe,
    output logic                o_irq
);

    logic [NUM_PINS-1:0]  out_q, out_d;
    logic [NUM_PINS-1:0]  dir_q, dir_d;
    logic [NUM_PINS-1:0]  edge_q, edge_d;
    logic [NUM_PINS-1:0]  irqen_q, irqen_d;
    logic [NUM_PINS-1:0]  in_sync, in_d_q;
    logic [NUM_PINS-1:0]  wdata_pins, clr_mask, rise;
    logic [31:0]          rdata_q, rdata_d, rd_val;
    logic                 rvalid_q, irq_q, irq_d;
    logic                 hit, wr_en;
    logic [REG_IDX_W-1:0] reg_idx;
    logic                 unused_bits;

    // Byte-lane bits and data bits above the pin count carry no meaning.
    assign unused_bits = ^{i_address[1:0], i_wdata};

    assign hit        = (i_address[31:5] == BASE_ADDR[31:5]);
    assign reg_idx    = i_address[4:2];
    assign wr_en      = i_write_cs & hit;
    assign wdata_pins = i_wdata[NUM_PINS-1:0];

    gpio_sync #(
        .WIDTH  (NUM_PINS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_gpio_in),
        .o_sync  (in_sync)
    );

    // Register-file write decode, including the atomic OUT updates and the EDGE W1C mask.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        irqen_d  = irqen_q;
        clr_mask = '0;
        if (wr_en) begin
            case (reg_idx)
                REG_OUT:   out_d    = wdata_pins;
                REG_DIR:   dir_d    = wdata_pins;
                REG_SET:   out_d    = out_q | wdata_pins;
                REG_CLR:   out_d    = out_q & ~wdata_pins;
                REG_TGL:   out_d    = out_q ^ wdata_pins;
                REG_EDGE:  clr_mask = wdata_pins;
                REG_IRQEN: irqen_d  = wdata_pins;
                default:   ;
            endcase
        end
    end

    // Edge capture: a fresh rise wins over a simultaneous W1C so no event is lost.
    always_comb begin
        rise   = in_sync & ~in_d_q;
        edge_d = (edge_q & ~clr_mask) | rise;
        irq_d  = |(edge_d & irqen_q);
    end

    // Read mux over pre-write register values; write-only slots read as zero.
    always_comb begin
        rd_val = '0;
        case (reg_idx)
            REG_OUT:   rd_val[NUM_PINS-1:0] = out_q;
            REG_DIR:   rd_val[NUM_PINS-1:0] = dir_q;
            REG_IN:    rd_val[NUM_PINS-1:0] = in_sync;
            REG_EDGE:  rd_val[NUM_PINS-1:0] = edge_q;
            REG_IRQEN: rd_val[NUM_PINS-1:0] = irqen_q;
            default:   rd_val = '0;
        endcase
    end

    // Read data register: loaded on any read strobe (zero on a miss), held otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (i_read_cs) begin
            rdata_d = hit ? rd_val : 32'h0;
        end
    end

    // All architectural state, with immediate clear on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q    <= '0;
            dir_q    <= '0;
            edge_q   <= '0;
            irqen_q  <= '0;
            in_d_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            edge_q   <= edge_d;
            irqen_q  <= irqen_d;
            in_d_q   <= in_sync;
            rdata_q  <= rdata_d;
            rvalid_q <= i_read_cs;
            irq_q    <= irq_d;
        end
    end

    assign o_gpio_out = out_q;
    assign o_gpio_oe  = dir_q;
    assign o_rdata    = rdata_q;
    assign o_rvalid   = rvalid_q;
    assign o_irq      = irq_q;

endmodule

// File: tb/tb_gpio_mmio_ctrl.sv
// Bench for gpio_mmio_ctrl: an 8-pin/2-stage and a 32-pin/3-stage instance
// share one bus; a register-level reference model predicts every output.
module tb_gpio_mmio_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        read_cs = 1'b0;
  logic        write_cs = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  gpio_in8 = '0;
  logic [31:0] gpio_in32 = '0;
  logic [31:0] rdata8, rdata32;
  logic        rvalid8, rvalid32, irq8, irq32;
  logic [7:0]  out8, oe8;
  logic [31:0] out32, oe32;

  int vectors = 0;
  int miscompares = 0;

  gpio_mmio_ctrl #(.BASE_ADDR(BASE), .NUM_PINS(8), .SYNC_STAGES(2)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_read_cs(read_cs), .i_write_cs(write_cs),
    .i_address(address), .i_wdata(wdata), .o_rdata(rdata8), .o_rvalid(rvalid8),
    .i_gpio_in(gpio_in8), .o_gpio_out(out8), .o_gpio_oe(oe8), .o_irq(irq8)
  );

  gpio_mmio_ctrl #(.BASE_ADDR(BASE), .NUM_PINS(32), .SYNC_STAGES(3)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_read_cs(read_cs), .i_write_cs(write_cs),
    .i_address(address), .i_wdata(wdata), .o_rdata(rdata32), .o_rvalid(rvalid32),
    .i_gpio_in(gpio_in32), .o_gpio_out(out32), .o_gpio_oe(oe32), .o_irq(irq32)
  );

  // ---------------- reference model ----------------
  // Index 0 models the 8-pin instance, index 1 the 32-pin instance.
  logic [31:0] m_out [2];
  logic [31:0] m_dir [2];
  logic [31:0] m_edge [2];
  logic [31:0] m_irqen [2];
  logic [31:0] m_rdata [2];
  logic        m_rvalid [2];
  logic        m_irq [2];
  // Pin samples taken at each clock edge, newest first.
  logic [31:0] hq0[$];
  logic [31:0] hq1[$];

  function automatic int stages(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [31:0] pin_mask(input int k);
    return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] hist_get(input int k, input int i);
    return (k == 0) ? hq0[i] : hq1[i];
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      m_out[k] = '0; m_dir[k] = '0; m_edge[k] = '0; m_irqen[k] = '0;
      m_rdata[k] = '0; m_rvalid[k] = 1'b0; m_irq[k] = 1'b0;
    end
    hq0.delete(); hq1.delete();
    for (int i = 0; i <= stages(0); i++) hq0.push_back('0);
    for (int i = 0; i <= stages(1); i++) hq1.push_back('0);
  endtask

  // One clock edge of register-level behaviour for instance k.
  task automatic model_step(input int k, input logic [31:0] pin);
    logic [31:0] in_now, in_prev, rd, w, clr, old_irqen;
    logic        hit;
    int          idx;
    // IN is the pin as it was SYNC_STAGES edges ago; IN_d one edge older.
    in_now  = hist_get(k, stages(k) - 1);
    in_prev = hist_get(k, stages(k));
    if (k == 0) begin hq0.push_front(pin & pin_mask(k)); void'(hq0.pop_back()); end
    else        begin hq1.push_front(pin & pin_mask(k)); void'(hq1.pop_back()); end

    hit = ((address & 32'hFFFF_FFE0) == BASE);
    idx = int'((address >> 2) & 32'h7);
    w   = wdata & pin_mask(k);
    case (idx)
      0: rd = m_out[k];
      1: rd = m_dir[k];
      2: rd = in_now;
      6: rd = m_edge[k];
      7: rd = m_irqen[k];
      default: rd = '0;
    endcase
    m_rvalid[k] = read_cs;
    if (read_cs) m_rdata[k] = hit ? rd : 32'h0;

    old_irqen = m_irqen[k];
    clr = '0;
    if (write_cs && hit) begin
      case (idx)
        0: m_out[k] = w;
        1: m_dir[k] = w;
        3: m_out[k] = m_out[k] | w;
        4: m_out[k] = m_out[k] & ~w;
        5: m_out[k] = m_out[k] ^ w;
        6: clr = w;
        7: m_irqen[k] = w;
        default: ;
      endcase
    end
    m_edge[k] = (m_edge[k] & ~clr) | (in_now & ~in_prev);
    m_irq[k]  = |(m_edge[k] & old_irqen);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("out8",    {24'b0, out8},    m_out[0]);
    chk("oe8",     {24'b0, oe8},     m_dir[0]);
    chk("irq8",    {31'b0, irq8},    {31'b0, m_irq[0]});
    chk("rvalid8", {31'b0, rvalid8}, {31'b0, m_rvalid[0]});
    chk("rdata8",  rdata8,           m_rdata[0]);
    chk("out32",   out32,            m_out[1]);
    chk("oe32",    oe32,             m_dir[1]);
    chk("irq32",   {31'b0, irq32},   {31'b0, m_irq[1]});
    chk("rvalid32",{31'b0, rvalid32},{31'b0, m_rvalid[1]});
    chk("rdata32", rdata32,          m_rdata[1]);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed at the falling edge; the model advances at the rising
  // edge and outputs are compared at the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) reset_model();
    else begin
      model_step(0, {24'b0, gpio_in8});
      model_step(1, gpio_in32);
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] reg_addr(input int idx);
    return BASE | (32'(idx) << 2);
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address = a; wdata = d; write_cs = 1'b1;
    tick();
    write_cs = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    address = a; read_cs = 1'b1;
    tick();
    read_cs = 1'b0;
  endtask

  task automatic bus_rw(input logic [31:0] a, input logic [31:0] d);
    address = a; wdata = d; read_cs = 1'b1; write_cs = 1'b1;
    tick();
    read_cs = 1'b0; write_cs = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  r_idx;
  logic [31:0] r_addr;
  int          r_op;

  initial begin
    reset_model();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Direction register drives the output enables.
    bus_write(reg_addr(1), 32'hA5A5_5A5A);
    chk("dir_oe8", {24'b0, oe8}, 32'h5A);

    // Asynchronous reset in the middle of a cycle.
    bus_write(reg_addr(0), 32'h0000_00FF);
    chk("pre_reset_out8", {24'b0, out8}, 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out8", {24'b0, out8}, 32'h0);
    chk("async_rst_oe8",  {24'b0, oe8},  32'h0);
    chk("async_rst_irq8", {31'b0, irq8}, 32'h0);
    chk("async_rst_out32", out32, 32'h0);
    reset_model();
    tick();
    rst_n = 1'b1;
    tick();

    // Atomic set / clear / toggle.
    bus_write(reg_addr(0), 32'h0F);
    bus_write(reg_addr(3), 32'hF0);
    chk("atomic_set", {24'b0, out8}, 32'hFF);
    bus_write(reg_addr(4), 32'h3C);
    chk("atomic_clr", {24'b0, out8}, 32'hC3);
    bus_write(reg_addr(5), 32'hFF);
    chk("atomic_tgl", {24'b0, out8}, 32'h3C);
    bus_read(reg_addr(0));
    chk("read_out_valid", {31'b0, rvalid8}, 32'h1);
    chk("read_out_data",  rdata8, 32'h3C);
    tick();
    chk("rvalid_drop", {31'b0, rvalid8}, 32'h0);

    // Rising edge to interrupt, then W1C, then a falling edge.
    bus_write(reg_addr(7), 32'h04);
    gpio_in8 = 8'h04; gpio_in32 = 32'h04;
    tick(); tick();
    chk("irq8_not_yet", {31'b0, irq8}, 32'h0);
    tick();
    chk("irq8_set", {31'b0, irq8}, 32'h1);
    chk("irq32_not_yet", {31'b0, irq32}, 32'h0);
    tick();
    chk("irq32_set", {31'b0, irq32}, 32'h1);
    bus_read(reg_addr(6));
    chk("edge8_read", rdata8, 32'h04);
    chk("edge32_read", rdata32, 32'h04);
    bus_write(reg_addr(6), 32'h04);
    chk("irq8_cleared", {31'b0, irq8}, 32'h0);
    chk("irq32_cleared", {31'b0, irq32}, 32'h0);
    gpio_in8 = 8'h00; gpio_in32 = 32'h0;
    repeat (5) tick();
    chk("fall_no_irq", {31'b0, irq8}, 32'h0);
    bus_read(reg_addr(6));
    chk("fall_no_edge", rdata8, 32'h0);

    // W1C landing on the same edge as a new rise keeps the bit.
    gpio_in8 = 8'h02; gpio_in32 = 32'h02;
    tick(); tick();
    bus_write(reg_addr(6), 32'h02);
    bus_read(reg_addr(6));
    chk("race_edge_kept", rdata8, 32'h02);
    bus_write(reg_addr(6), 32'hFFFF_FFFF);

    // Decode: misses and write-only reads.
    bus_write(BASE + 32'h20, 32'hDEAD_BEEF);
    chk("miss_write_out", {24'b0, out8}, 32'h3C);
    bus_read(reg_addr(0));
    chk("read_out_again", rdata8, 32'h3C);
    bus_read(BASE + 32'h20);
    chk("miss_read_valid", {31'b0, rvalid8}, 32'h1);
    chk("miss_read_zero", rdata8, 32'h0);
    bus_read(reg_addr(0));
    bus_read(reg_addr(3));
    chk("wo_read_zero", rdata8, 32'h0);
    bus_rw(reg_addr(0), 32'h55);
    chk("rw_old_value", rdata8, 32'h3C);
    chk("rw_new_out", {24'b0, out8}, 32'h55);

    // Full-width toggle on the 32-pin instance.
    bus_write(reg_addr(5), 32'hFFFF_FFFF);
    chk("tgl32_all", out32, 32'hFFFF_FFAA);
    chk("tgl8_all", {24'b0, out8}, 32'hAA);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r_op  = $urandom_range(0, 9);
      r_idx = 3'($urandom_range(0, 7));
      r_addr = (($urandom_range(0, 7) == 0) ? (BASE + 32'h20) : BASE)
               | {27'b0, r_idx, 2'b00} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        gpio_in8  = 8'($urandom);
        gpio_in32 = $urandom;
      end
      address  = r_addr;
      wdata    = $urandom;
      read_cs  = (r_op < 4) || (r_op == 8);
      write_cs = (r_op >= 4 && r_op < 7) || (r_op == 8);
      tick();
      read_cs  = 1'b0;
      write_cs = 1'b0;
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
